ifu_fetch: RTL and testbench

//   Instruction fetch stage; sits directly upstream of the decode stage.

---
 rtl/npc_pkg.sv | 19 +
 rtl/ifu_fetch_if.sv | 41 ++++
 rtl/ifu_fetch.sv | 130 +++++++++++++
 tb/tb_ifu_fetch.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared fetch-stage types and constants.
package npc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // Word-align a fetch target by clearing the two low bits.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus bundle: execute redirect, imem request/response and decode output.
interface ifu_fetch_if #(
  parameter int XLEN = 32
);

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;

  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;

  // Fetch-stage side.
  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output out_valid, out_inst, out_pc,
    input  out_ready
  );

  // Memory / execute / decode side.
  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  out_valid, out_inst, out_pc,
    output out_ready
  );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch: PC, single outstanding imem request, one-entry output buffer (IFU_PERF_CNT_EN adds counters).
// Latency: request handshake at N, response N+1, out_valid N+2.
// Backpressure: holds request until accepted; holds {inst,pc} until decode takes it.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
`ifdef IFU_PERF_CNT_EN
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt,
`endif
  ifu_fetch_if.master bus
);

  ifu_state_t      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_inst_q, out_inst_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;

  logic            redirect;
  logic            req_fire;
  logic            out_fire;
  logic [XLEN-1:0] redirect_target;

  // IDLE is excluded so the post-reset bubble is never skipped.
  assign redirect        = bus.redirect_valid && (state_q != IDLE);
  assign req_fire        = (state_q == REQ) && bus.imem_req_ready;
  assign out_fire        = out_valid_q && bus.out_ready;
  assign redirect_target = {bus.redirect_pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_inst_q  <= NOP_INST;
      out_pc_q    <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;

    case (state_q)
      IDLE: state_d = REQ;

      REQ: begin
        if (req_fire) begin
          state_d = WAIT;
          // The accepted request carried the old PC; its reply must be discarded.
          if (redirect) drop_d = 1'b1;
        end
      end

      WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            out_inst_d  = bus.imem_rsp_data;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end

      HOLD: begin
        if (out_fire) begin
          pc_d        = pc_q + XLEN'(4);
          out_valid_d = 1'b0;
          state_d     = REQ;
        end
      end

      default: state_d = IDLE;
    endcase

    // Redirect overrides any sequential PC update decided above.
    if (redirect) begin
      pc_d        = redirect_target;
      out_valid_d = 1'b0;
      if (state_q == HOLD) state_d = REQ;
    end
  end

  assign bus.imem_req_valid = (state_q == REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_inst       = out_inst_q;
  assign bus.out_pc         = out_pc_q;

`ifdef IFU_PERF_CNT_EN
  logic stall_cycle;
  assign stall_cycle = ((state_q == REQ) || (state_q == WAIT)) && !bus.redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 64'd0;
      perf_stall_cnt <= 64'd0;
    end else begin
      if (out_fire)    perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (stall_cycle) perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a delay-programmable instruction memory responder.
module tb_ifu_fetch;
  import npc_pkg::*;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rsp_delay = 0;
  bit   found;

`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  ifu_fetch_if #(.XLEN(32)) bus ();

  ifu_fetch #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef IFU_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .bus            (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model: replies rsp_delay cycles after the cycle following each request handshake.
  initial begin : responder
    logic        hs;
    logic [31:0] hs_addr;
    logic [31:0] pend_addr;
    int          cnt;
    cnt = 0;
    pend_addr = '0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      hs      = bus.imem_req_valid && bus.imem_req_ready && !rst;
      hs_addr = bus.imem_req_addr;
      @(posedge clk);
      #1;
      bus.imem_rsp_valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = inst_of(pend_addr);
        end
      end
      if (hs) begin
        if (rsp_delay == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = inst_of(hs_addr);
        end else begin
          cnt       = rsp_delay;
          pend_addr = hs_addr;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_out(input string name, output bit ok);
    for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
    ok = bus.out_valid;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: out_valid timeout, got %b want 1", name, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valids: req_valid=%b out_valid=%b want 0/0", bus.imem_req_valid, bus.out_valid);
    end
    n_tests++;
    if (bus.out_inst !== NOP_INST || bus.out_pc !== RPC || bus.imem_req_addr !== RPC) begin
      n_fail++;
      $display("FAIL reset_data: inst=%h pc=%h addr=%h want %h/%h/%h",
               bus.out_inst, bus.out_pc, bus.imem_req_addr, NOP_INST, RPC, RPC);
    end
  endtask

  task automatic test_basic();
    rst = 1'b0;
    tick();
    n_tests++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RPC) begin
      n_fail++;
      $display("FAIL first_req: valid=%b addr=%h want 1/%h", bus.imem_req_valid, bus.imem_req_addr, RPC);
    end
    tick();
    n_tests++;
    if (bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_state: req_valid=%b out_valid=%b want 0/0", bus.imem_req_valid, bus.out_valid);
    end
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== RPC || bus.out_inst !== inst_of(RPC)) begin
      n_fail++;
      $display("FAIL first_out: valid=%b pc=%h inst=%h want 1/%h/%h",
               bus.out_valid, bus.out_pc, bus.out_inst, RPC, inst_of(RPC));
    end
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0004) begin
      n_fail++;
      $display("FAIL after_consume: out_valid=%b req_valid=%b addr=%h want 0/1/80000004",
               bus.out_valid, bus.imem_req_valid, bus.imem_req_addr);
    end
    wait_out("out_pc4", found);
    n_tests++;
    if (bus.out_pc !== 32'h8000_0004 || bus.out_inst !== inst_of(32'h8000_0004)) begin
      n_fail++;
      $display("FAIL out_pc4: pc=%h inst=%h want 80000004/%h", bus.out_pc, bus.out_inst, inst_of(32'h8000_0004));
    end
    tick();
    wait_out("out_pc8", found);
    n_tests++;
    if (bus.out_pc !== 32'h8000_0008 || bus.out_inst !== inst_of(32'h8000_0008)) begin
      n_fail++;
      $display("FAIL out_pc8: pc=%h inst=%h want 80000008/%h", bus.out_pc, bus.out_inst, inst_of(32'h8000_0008));
    end
  endtask

  task automatic test_hold_stall();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8000_0008 ||
          bus.out_inst !== inst_of(32'h8000_0008) || bus.imem_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: valid=%b pc=%h inst=%h req_valid=%b want 1/80000008/%h/0",
                 i, bus.out_valid, bus.out_pc, bus.out_inst, bus.imem_req_valid, inst_of(32'h8000_0008));
      end
    end
    bus.out_ready = 1'b1;
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_addr !== 32'h8000_000C) begin
      n_fail++;
      $display("FAIL hold_release: out_valid=%b addr=%h want 0/8000000c", bus.out_valid, bus.imem_req_addr);
    end
  endtask

  task automatic test_redirect_wait();
    rsp_delay = 2;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    tick();
    bus.redirect_valid = 1'b0;
    n_tests++;
    if (bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_wait_stay: req_valid=%b out_valid=%b want 0/0", bus.imem_req_valid, bus.out_valid);
    end
    tick();
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0100) begin
      n_fail++;
      $display("FAIL redir_wait_drop: out_valid=%b req_valid=%b addr=%h want 0/1/80000100",
               bus.out_valid, bus.imem_req_valid, bus.imem_req_addr);
    end
    rsp_delay = 0;
    bus.out_ready = 1'b0;
    wait_out("redir_wait_out", found);
    n_tests++;
    if (bus.out_pc !== 32'h8000_0100 || bus.out_inst !== inst_of(32'h8000_0100)) begin
      n_fail++;
      $display("FAIL redir_wait_out: pc=%h inst=%h want 80000100/%h", bus.out_pc, bus.out_inst, inst_of(32'h8000_0100));
    end
  endtask

  task automatic test_redirect_hold();
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0203;
    tick();
    bus.redirect_valid = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0200) begin
      n_fail++;
      $display("FAIL redir_hold_req: out_valid=%b req_valid=%b addr=%h want 0/1/80000200",
               bus.out_valid, bus.imem_req_valid, bus.imem_req_addr);
    end
    wait_out("redir_hold_out", found);
    n_tests++;
    if (bus.out_pc !== 32'h8000_0200 || bus.out_inst !== inst_of(32'h8000_0200)) begin
      n_fail++;
      $display("FAIL redir_hold_out: pc=%h inst=%h want 80000200/%h", bus.out_pc, bus.out_inst, inst_of(32'h8000_0200));
    end
  endtask

  task automatic test_wrap();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFF;
    tick();
    bus.redirect_valid = 1'b0;
    wait_out("wrap_top", found);
    n_tests++;
    if (bus.out_pc !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_top: pc=%h want fffffffc", bus.out_pc);
    end
    tick();
    wait_out("wrap_zero", found);
    n_tests++;
    if (bus.out_pc !== 32'h0000_0000 || bus.out_inst !== inst_of(32'h0)) begin
      n_fail++;
      $display("FAIL wrap_zero: pc=%h inst=%h want 00000000/%h", bus.out_pc, bus.out_inst, inst_of(32'h0));
    end
  endtask

  task automatic test_req_backpressure_reset();
    bus.imem_req_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0000_0004) begin
        n_fail++;
        $display("FAIL req_hold[%0d]: valid=%b addr=%h want 1/00000004", i, bus.imem_req_valid, bus.imem_req_addr);
      end
      if (i < 3) tick();
    end
    rsp_delay = 1;
    bus.imem_req_ready = 1'b1;
    tick();
    n_tests++;
    if (bus.imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL req_accept: req_valid=%b want 0", bus.imem_req_valid);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== RPC) begin
      n_fail++;
      $display("FAIL rst_mid_wait: out_valid=%b req_valid=%b addr=%h want 0/0/%h",
               bus.out_valid, bus.imem_req_valid, bus.imem_req_addr, RPC);
    end
    tick();
    rst = 1'b0;
    tick();
    rsp_delay = 0;
    n_tests++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RPC || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL late_rsp_ignored: req_valid=%b addr=%h out_valid=%b want 1/%h/0",
               bus.imem_req_valid, bus.imem_req_addr, bus.out_valid, RPC);
    end
    wait_out("post_rst_out", found);
    n_tests++;
    if (bus.out_pc !== RPC || bus.out_inst !== inst_of(RPC)) begin
      n_fail++;
      $display("FAIL post_rst_out: pc=%h inst=%h want %h/%h", bus.out_pc, bus.out_inst, RPC, inst_of(RPC));
    end
  endtask

`ifdef IFU_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_out("perf_fetch", found);
      tick();
    end
    n_tests++;
    if (perf_fetch_cnt !== 64'd10 || perf_stall_cnt !== 64'd20) begin
      n_fail++;
      $display("FAIL perf_cnt: fetch=%0d stall=%0d want 10/20", perf_fetch_cnt, perf_stall_cnt);
    end
  endtask
`endif

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b1;
    bus.out_ready      = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    test_reset();
    test_basic();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_req_backpressure_reset();
`ifdef IFU_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
